// File: rtl/digit_serial_adder_pkg.sv
// Shared types and defaults for the digit-serial adder.
// FSM state encoding plus default operand/digit widths.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/digit_serial_adder_adder_nbit.sv
// Parametrised ripple-carry adder for one digit slice.
// Also exposes the carry into its top bit for overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[N];
  assign cmsb = c[N-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle.
// Results are exposed only once the final slice completes.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  if (DIGIT < 1 || DIGIT > WIDTH ||
      (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("digit_serial_adder: bad WIDTH/DIGIT");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic [DIGIT-1:0] sum_w;
  logic             cout_w;
  logic             cmsb_w;
  logic [WIDTH-1:0] acc_nx;

  adder_nbit #(
    .N (DIGIT)
  ) u_add (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (cy_q),
    .sum  (sum_w),
    .cout (cout_w),
    .cmsb (cmsb_w)
  );

  // New slice enters at the top; after N shifts S is aligned.
  assign acc_nx = (acc_q >> DIGIT) |
                  (WIDTH'(sum_w) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    c_d     = c_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = sub ? ~B : B;
          cy_d    = sub ? 1'b1 : C0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        acc_d = acc_nx;
        cy_d  = cout_w;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          s_d     = acc_nx;
          c_d     = cout_w;
          v_d     = cmsb_w ^ cout_w;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign C    = c_q;
  assign V    = v_q;

endmodule
